// File: rtl/dvi_decoder.sv
// TMDS 10b->8b channel decoder: aligns the raw deserializer word by bit-slipping until control tokens line up,
// then decodes pixels and control bits. Latency: din -> outputs is 2 clkin edges after the word lands in din_q.
// No backpressure: one word is accepted and one output set is produced on every clkin edge.
module dvi_decoder #(
    parameter int LOCK_CNT       = 8,
    parameter int SEARCH_TIMEOUT = 1024,
    parameter int MAX_ACTIVE     = 4096
) (
    input  logic       clkin,
    input  logic       rstin,
    input  logic [9:0] din,
    output logic [7:0] dout,
    output logic       de,
    output logic       c0,
    output logic       c1,
    output logic       locked,
    output logic [3:0] offset
);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED, SLIP} state_t;

    localparam logic [12:0] LOCK_LIM   = 13'(LOCK_CNT);
    localparam logic [12:0] SEARCH_LIM = 13'(SEARCH_TIMEOUT);
    localparam logic [12:0] ACTIVE_LIM = 13'(MAX_ACTIVE);

    state_t      state;
    logic [12:0] cnt;
    logic [12:0] cnt_inc;
    logic [9:0]  din_q;
    logic [9:0]  aw;
    logic [9:0]  window;
    logic [19:0] both;
    logic [4:0]  off_ext;
    logic        is_tok;
    logic [1:0]  tok_c;
    logic [7:0]  t;
    logic [7:0]  q;
    logic        slip_now;

    // The character may straddle two deserializer words, so the window spans the previous and current word.
    assign both    = {din, din_q};
    assign off_ext = {1'b0, offset};
    assign window  = both[off_ext +: 10];

    // Counter saturates so a long run can never wrap back below a limit.
    assign cnt_inc = (cnt == 13'h1fff) ? cnt : cnt + 13'd1;

    // Stage A/B: capture the raw word, then the aligned character.
    always_ff @(posedge clkin or posedge rstin) begin
        if (rstin) begin
            din_q <= '0;
            aw    <= '0;
        end else begin
            din_q <= din;
            aw    <= window;
        end
    end

    // Recognise the four control tokens on the aligned character.
    always_comb begin
        is_tok = 1'b1;
        tok_c  = 2'b00;
        case (aw)
            10'b1101010100: tok_c = 2'b00;
            10'b0010101011: tok_c = 2'b01;
            10'b0101010100: tok_c = 2'b10;
            10'b1010101011: tok_c = 2'b11;
            default:        is_tok = 1'b0;
        endcase
    end

    // Undo the transition-minimising XOR/XNOR chain and the DC-balance inversion.
    always_comb begin
        t    = aw[9] ? ~aw[7:0] : aw[7:0];
        q    = '0;
        q[0] = t[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = aw[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
        end
    end

    // Conditions that abandon the current offset; a token always takes priority over a timeout.
    always_comb begin
        slip_now = 1'b0;
        case (state)
            SEARCH:  slip_now = !is_tok && (cnt_inc >= SEARCH_LIM);
            VERIFY:  slip_now = !is_tok;
            LOCKED:  slip_now = !is_tok && (cnt_inc >= ACTIVE_LIM);
            default: slip_now = 1'b0;
        endcase
    end

    // Alignment FSM with registered outputs; outputs follow the state being entered on this edge.
    always_ff @(posedge clkin or posedge rstin) begin
        if (rstin) begin
            state  <= SEARCH;
            cnt    <= '0;
            offset <= '0;
            dout   <= '0;
            de     <= 1'b0;
            c0     <= 1'b0;
            c1     <= 1'b0;
            locked <= 1'b0;
        end else if (slip_now) begin
            state  <= SLIP;
            cnt    <= '0;
            offset <= (offset == 4'd9) ? 4'd0 : offset + 4'd1;
            dout   <= '0;
            de     <= 1'b0;
            c0     <= 1'b0;
            c1     <= 1'b0;
            locked <= 1'b0;
        end else begin
            case (state)
                SEARCH: begin
                    if (is_tok) begin
                        state <= VERIFY;
                        cnt   <= 13'd1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                VERIFY: begin
                    if (cnt_inc >= LOCK_LIM) begin
                        state      <= LOCKED;
                        cnt        <= '0;
                        locked     <= 1'b1;
                        de         <= 1'b0;
                        {c1, c0}   <= tok_c;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                LOCKED: begin
                    if (is_tok) begin
                        cnt      <= '0;
                        de       <= 1'b0;
                        {c1, c0} <= tok_c;
                    end else begin
                        cnt  <= cnt_inc;
                        de   <= 1'b1;
                        dout <= q;
                    end
                end
                default: begin
                    // Two settle cycles so aw is rebuilt from the new offset before searching.
                    if (cnt == 13'd1) begin
                        state <= SEARCH;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dvi_decoder.sv
module tb_dvi_decoder;

    localparam int LOCK_CNT       = 8;
    localparam int SEARCH_TIMEOUT = 16;
    localparam int MAX_ACTIVE     = 16;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T10 = 10'b0101010100;
    localparam logic [9:0] T11 = 10'b1010101011;

    logic       clkin = 1'b0;
    logic       rstin;
    logic [9:0] din;
    logic [7:0] dout;
    logic       de, c0, c1, locked;
    logic [3:0] offset;

    int errors = 0;
    int checks = 0;

    dvi_decoder #(
        .LOCK_CNT(LOCK_CNT),
        .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
        .MAX_ACTIVE(MAX_ACTIVE)
    ) dut (
        .clkin(clkin),
        .rstin(rstin),
        .din(din),
        .dout(dout),
        .de(de),
        .c0(c0),
        .c1(c1),
        .locked(locked),
        .offset(offset)
    );

    always #5 clkin = ~clkin;

    wire [15:0] dut_vec = {dout, de, c0, c1, locked, offset};

    // Reference model: mode 0 search, 1 verify, 2 locked, 3 slip.
    logic [9:0] m_dq, m_aw;
    int         m_off, m_mode, m_streak, m_idle, m_active, m_hold;
    logic [7:0] m_dout;
    logic       m_de, m_c0, m_c1;

    logic [9:0] toks [4];
    bit         sbits [$];

    function automatic int tok_code(input logic [9:0] w);
        if (w == T00) return 0;
        if (w == T01) return 1;
        if (w == T10) return 2;
        if (w == T11) return 3;
        return -1;
    endfunction

    function automatic logic [7:0] tmds_dec(input logic [9:0] w);
        logic [7:0] x;
        x = w[9] ? ~w[7:0] : w[7:0];
        if (w[8]) return x ^ {x[6:0], 1'b0};
        return x ^ {~x[6:0], 1'b0};
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        w = 10'($urandom);
        if (tok_code(w) >= 0) w = w ^ 10'h001;
        return w;
    endfunction

    function automatic logic [15:0] exp_vec();
        return {m_dout, m_de, m_c0, m_c1, (m_mode == 2), 4'(m_off)};
    endfunction

    task automatic model_reset();
        m_dq = '0; m_aw = '0; m_off = 0; m_mode = 0;
        m_streak = 0; m_idle = 0; m_active = 0; m_hold = 0;
        m_dout = '0; m_de = 1'b0; m_c0 = 1'b0; m_c1 = 1'b0;
    endtask

    task automatic model_step(input logic [9:0] d);
        logic [19:0] cat;
        int          code;
        bit          slip;
        cat  = {d, m_dq} >> m_off;
        code = tok_code(m_aw);
        slip = 0;
        case (m_mode)
            0: if (code >= 0) begin m_mode = 1; m_streak = 1; end
               else begin m_idle++; if (m_idle >= SEARCH_TIMEOUT) slip = 1; end
            1: if (code >= 0) begin
                   m_streak++;
                   if (m_streak >= LOCK_CNT) begin m_mode = 2; m_active = 0; end
               end else slip = 1;
            2: if (code >= 0) m_active = 0;
               else begin m_active++; if (m_active >= MAX_ACTIVE) slip = 1; end
            default: begin m_hold--; if (m_hold == 0) begin m_mode = 0; m_idle = 0; end end
        endcase
        if (slip) begin
            m_mode = 3; m_hold = 2; m_off = (m_off + 1) % 10;
        end
        if (m_mode == 2) begin
            if (code >= 0) begin m_de = 1'b0; m_c1 = code[1]; m_c0 = code[0]; end
            else begin m_de = 1'b1; m_dout = tmds_dec(m_aw); end
        end else begin
            m_de = 1'b0; m_c0 = 1'b0; m_c1 = 1'b0; m_dout = '0;
        end
        m_dq = d;
        m_aw = cat[9:0];
    endtask

    task automatic step(input logic [9:0] d);
        din = d;
        @(posedge clkin);
        model_step(d);
        #1;
    endtask

    task automatic push_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) sbits.push_back(w[i]);
    endtask

    function automatic logic [9:0] pop_word();
        logic [9:0] w;
        w = '0;
        for (int i = 0; i < 10; i++) w[i] = (sbits.size() > 0) ? sbits.pop_front() : 1'b0;
        return w;
    endfunction

    task automatic do_reset();
        rstin = 1'b1;
        din   = 10'($urandom);
        @(posedge clkin);
        #1;
        rstin = 1'b0;
        model_reset();
        sbits.delete();
    endtask

    task automatic test_reset();
        rstin = 1'b1;
        din   = '0;
        #1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (dut_vec !== 16'h0000) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=0000", i, dut_vec);
            end
            din = 10'($urandom);
            @(posedge clkin);
            #1;
        end
        rstin = 1'b0;
        model_reset();
        sbits.delete();
    endtask

    task automatic test_aligned_lock();
        logic [9:0] seq [16];
        for (int i = 0; i < 10; i++) seq[i] = T00;
        seq[10] = 10'b0100000000;
        seq[11] = 10'b1000000000;
        for (int i = 12; i < 16; i++) seq[i] = T00;
        for (int i = 0; i < 16; i++) begin
            step(seq[i]);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL aligned_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
            if (i == 8) begin
                checks++;
                if (locked !== 1'b0) begin errors++; $display("FAIL aligned_early_lock got=%b exp=0", locked); end
            end
            if (i == 9) begin
                checks++;
                if ({locked, c1, c0, de} !== 4'b1000) begin
                    errors++; $display("FAIL aligned_lock_8th got=%b exp=1000", {locked, c1, c0, de});
                end
            end
            if (i == 11) begin
                checks++;
                if (de !== 1'b0) begin errors++; $display("FAIL aligned_de_before got=%b exp=0", de); end
            end
            if (i == 12) begin
                checks++;
                if ({de, dout} !== 9'h100) begin errors++; $display("FAIL aligned_data00 got=%h exp=100", {de, dout}); end
            end
            if (i == 13) begin
                checks++;
                if ({de, dout} !== 9'h1FF) begin errors++; $display("FAIL aligned_dataFF got=%h exp=1ff", {de, dout}); end
            end
            if (i == 14) begin
                checks++;
                if ({de, dout} !== 9'h0FF) begin errors++; $display("FAIL aligned_de_after got=%h exp=0ff", {de, dout}); end
            end
        end
    endtask

    task automatic test_all_tokens();
        logic [9:0] seq [12];
        logic [7:0] last_pix;
        int         code;
        seq[0] = rand_data(); seq[1] = T01; seq[2] = rand_data(); seq[3] = T10;
        seq[4] = rand_data(); seq[5] = T11; seq[6] = T01;         seq[7] = T10;
        seq[8] = T11;         seq[9] = rand_data(); seq[10] = T00; seq[11] = T00;
        last_pix = 8'hFF;
        for (int i = 0; i < 12; i++) begin
            step(seq[i]);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL tokens_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
            if (i >= 2) begin
                code = tok_code(seq[i-2]);
                checks++;
                if (code >= 0) begin
                    if ({locked, de, c1, c0, dout} !== {2'b10, 2'(code), last_pix}) begin
                        errors++;
                        $display("FAIL tokens_ctrl cyc=%0d got=%h exp=%h", i, {locked, de, c1, c0, dout}, {2'b10, 2'(code), last_pix});
                    end
                end else begin
                    last_pix = tmds_dec(seq[i-2]);
                    if ({locked, de, dout} !== {2'b11, last_pix}) begin
                        errors++;
                        $display("FAIL tokens_data cyc=%0d got=%h exp=%h", i, {locked, de, dout}, {2'b11, last_pix});
                    end
                end
            end
        end
    endtask

    task automatic test_misaligned();
        int       slips, false_lock;
        logic [3:0] prev_off;
        do_reset();
        for (int i = 0; i < 3; i++) sbits.push_back(1'b0);
        slips = 0; false_lock = 0; prev_off = offset;
        for (int i = 0; i < 120; i++) begin
            push_word(T00);
            step(pop_word());
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL misalign_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
            if (offset !== prev_off) slips++;
            if (locked === 1'b1 && offset < 4'd3) false_lock++;
            prev_off = offset;
        end
        checks++;
        if (slips != 3) begin errors++; $display("FAIL misalign_slips got=%0d exp=3", slips); end
        checks++;
        if ({offset, locked, c1, c0} !== {4'd3, 3'b100}) begin
            errors++; $display("FAIL misalign_final got=%h exp=%h", {offset, locked, c1, c0}, {4'd3, 3'b100});
        end
        checks++;
        if (false_lock != 0) begin errors++; $display("FAIL misalign_false_lock got=%0d exp=0", false_lock); end
    endtask

    task automatic test_lock_loss();
        logic [9:0] seq [$];
        int         fall_at, expect_fall;
        seq.delete();
        for (int i = 0; i < 4; i++) seq.push_back(T00);
        for (int i = 0; i < 15; i++) seq.push_back(rand_data());
        for (int i = 0; i < 4; i++) seq.push_back(T00);
        for (int i = 0; i < 16; i++) seq.push_back(rand_data());
        expect_fall = seq.size() - 1 + 2;
        for (int i = 0; i < 6; i++) seq.push_back(T00);
        fall_at = -1;
        for (int i = 0; i < seq.size(); i++) begin
            push_word(seq[i]);
            step(pop_word());
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL lockloss_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
            if (fall_at < 0 && locked !== 1'b1) begin
                fall_at = i;
                checks++;
                if ({offset, de} !== {4'd4, 1'b0}) begin
                    errors++; $display("FAIL lockloss_slip got=%h exp=%h", {offset, de}, {4'd4, 1'b0});
                end
            end
        end
        checks++;
        if (fall_at != expect_fall) begin
            errors++; $display("FAIL lockloss_when got=%0d exp=%0d", fall_at, expect_fall);
        end
    endtask

    task automatic test_reset_midlock();
        do_reset();
        for (int i = 0; i < 14; i++) step((i < 10) ? T00 : rand_data());
        checks++;
        if ({locked, de} !== 2'b11) begin errors++; $display("FAIL midlock_pre got=%b exp=11", {locked, de}); end
        rstin = 1'b1;
        #2;
        checks++;
        if (dut_vec !== 16'h0000) begin errors++; $display("FAIL midlock_async got=%h exp=0000", dut_vec); end
        @(posedge clkin);
        #1;
        rstin = 1'b0;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            step(T00);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL midlock_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
            if (i == 8 || i == 9) begin
                checks++;
                if ({locked, offset} !== {(i == 9), 4'd0}) begin
                    errors++; $display("FAIL midlock_relock cyc=%0d got=%h exp=%h", i, {locked, offset}, {(i == 9), 4'd0});
                end
            end
        end
    endtask

    task automatic test_soak();
        int  burst_left, lock_cycles;
        bit  burst_tok;
        do_reset();
        for (int i = 0; i < $urandom_range(0, 9); i++) sbits.push_back(1'($urandom));
        burst_left = 0; burst_tok = 0; lock_cycles = 0;
        for (int i = 0; i < 1500; i++) begin
            while (sbits.size() < 10) begin
                if (burst_left == 0) begin
                    burst_tok  = ($urandom_range(0, 2) != 0);
                    burst_left = burst_tok ? $urandom_range(9, 14) : $urandom_range(1, 18);
                end
                push_word(burst_tok ? toks[$urandom_range(0, 3)] : rand_data());
                burst_left--;
            end
            step(pop_word());
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL soak_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
            if (locked === 1'b1) lock_cycles++;
        end
        checks++;
        if (lock_cycles == 0) begin errors++; $display("FAIL soak_never_locked got=0 exp=>0"); end
    endtask

    initial begin
        toks[0] = T00; toks[1] = T01; toks[2] = T10; toks[3] = T11;
        test_reset();
        test_aligned_lock();
        test_all_tokens();
        test_misaligned();
        test_lock_loss();
        test_reset_midlock();
        test_soak();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
